// File: rtl/srio_initiator_arbiter_pkg.sv
// srio_initiator_arbiter_pkg: shared SRIO scheduler state, descriptor and length rule
package srio_initiator_arbiter_pkg;
   localparam int MAX_BYTES        = 256;
   localparam int UCFG_DEST_ADDR_W = 34;
   typedef enum logic [2:0] {
      IDLE, LATCH, LAUNCH, WAIT_RISE, WAIT_FALL, DB_LAUNCH, DB_WAIT, DONE
   } srio_state_e;
   typedef struct packed {
      logic [7:0]                  dest_id;
      logic [31:0]                 src_addr;
      logic [UCFG_DEST_ADDR_W-1:0] dest_addr;
      logic [8:0]                  byte_count;
      logic                        db;
      logic [15:0]                 db_info;
   } srio_desc_t;
   function automatic logic byte_count_ok(input logic [8:0] bc);
      return (bc != 9'd0) && (bc <= 9'(MAX_BYTES));
   endfunction
endpackage

// File: rtl/srio_initiator_arbiter_rr.sv
// rr_arbiter_onehot: combinational round-robin pick of the first request after ptr
module rr_arbiter_onehot #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);
   localparam int IW = $clog2(NUM_REQ);
   logic [IW-1:0] j;
   always_comb begin
      idx = '0;
      j   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = IW'((int'(ptr) + k) % NUM_REQ);
         if (req[j]) idx = j;
      end
      any = |req;
      gnt = any ? NUM_REQ'(1) << idx : '0;
   end
endmodule

// File: rtl/srio_initiator_arbiter.sv
// srio_initiator_arbiter: round-robin sharing of the SRIO initiator ucfg port between requesters
module srio_initiator_arbiter
   import srio_initiator_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [8*NUM_REQ-1:0]        req_dest_id,
   input  logic [32*NUM_REQ-1:0]       req_src_addr,
   input  logic [34*NUM_REQ-1:0]       req_dest_addr,
   input  logic [9*NUM_REQ-1:0]        req_byte_count,
   input  logic [NUM_REQ-1:0]          req_db,
   input  logic [16*NUM_REQ-1:0]       req_db_info,
   output logic [NUM_REQ-1:0]          req_ack,
   output logic [NUM_REQ-1:0]          req_done,
   output logic [NUM_REQ-1:0]          req_err,
   output logic [7:0]                  ucfg_dest_id,
   output logic [31:0]                 ucfg_src_start_addr,
   output logic [UCFG_DEST_ADDR_W-1:0] ucfg_dest_start_addr,
   output logic [8:0]                  ucfg_byte_count,
   output logic [15:0]                 ucfg_db_info,
   output logic                        ucfg_wr_n,
   output logic                        ucfg_normal_trigger,
   output logic                        ucfg_db_trigger,
   input  logic                        srio_initial_busy,
   input  logic                        srio_db_resp,
   output logic [31:0]                 xfer_count,
   output logic [15:0]                 timeout_count
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   srio_state_e   state_q, state_d;
   srio_desc_t    desc_q, desc_d, cand;
   srio_desc_t    descs [NUM_REQ];
   logic [IW-1:0] rr_ptr_q, rr_ptr_d, g_q, g_d, gidx;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [31:0]   xfer_count_q, xfer_count_d;
   logic [15:0]   timeout_count_q, timeout_count_d;
   logic [NUM_REQ-1:0] gnt;
   logic          any, in_wait;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign descs[i] = '{dest_id:    req_dest_id[8*i +: 8],
                          src_addr:   req_src_addr[32*i +: 32],
                          dest_addr:  req_dest_addr[34*i +: 34],
                          byte_count: req_byte_count[9*i +: 9],
                          db:         req_db[i],
                          db_info:    req_db_info[16*i +: 16]};
   end

   rr_arbiter_onehot #(.NUM_REQ(NUM_REQ)) u_rr (
      .req(req_valid), .ptr(rr_ptr_q), .gnt(gnt), .idx(gidx), .any(any)
   );

   assign cand = descs[gidx];
   assign in_wait = (state_q == WAIT_RISE) || (state_q == WAIT_FALL) || (state_q == DB_WAIT);

   always_comb begin
      state_d             = state_q;
      desc_d              = desc_q;
      rr_ptr_d            = rr_ptr_q;
      g_d                 = g_q;
      tmr_d               = tmr_q - TW'(1);
      xfer_count_d        = xfer_count_q;
      timeout_count_d     = timeout_count_q;
      req_ack             = '0;
      req_done            = '0;
      req_err             = '0;
      ucfg_normal_trigger = 1'b0;
      ucfg_db_trigger     = 1'b0;
      case (state_q)
         IDLE:      state_d = |req_valid ? LATCH : IDLE;
         LATCH: begin
            state_d = IDLE;
            req_ack = gnt;
            if (any && byte_count_ok(cand.byte_count)) begin
               desc_d  = cand;
               g_d     = gidx;
               state_d = LAUNCH;
            end else if (any) begin
               req_err  = gnt;
               rr_ptr_d = gidx;
            end
         end
         LAUNCH: begin
            ucfg_normal_trigger = 1'b1;
            state_d             = WAIT_RISE;
            tmr_d               = TW'(TIMEOUT_CYC - 1);
         end
         WAIT_RISE: if (srio_initial_busy) begin
            state_d = WAIT_FALL;
            tmr_d   = TW'(TIMEOUT_CYC - 1);
         end
         WAIT_FALL: if (!srio_initial_busy) state_d = desc_q.db ? DB_LAUNCH : DONE;
         DB_LAUNCH: begin
            ucfg_db_trigger = 1'b1;
            state_d         = DB_WAIT;
            tmr_d           = TW'(TIMEOUT_CYC - 1);
         end
         DB_WAIT:   if (srio_db_resp) state_d = DONE;
         DONE: begin
            req_done     = NUM_REQ'(1) << g_q;
            xfer_count_d = xfer_count_q + 32'd1;
            rr_ptr_d     = g_q;
            state_d      = IDLE;
         end
         default:   state_d = IDLE;
      endcase
      // A wait that is still unmet when its counter hits zero abandons the transfer
      if (in_wait && state_d == state_q && tmr_q == '0) begin
         req_err         = NUM_REQ'(1) << g_q;
         timeout_count_d = (timeout_count_q == 16'hFFFF) ? timeout_count_q : timeout_count_q + 16'd1;
         rr_ptr_d        = g_q;
         state_d         = IDLE;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q         <= IDLE;
         desc_q          <= '0;
         rr_ptr_q        <= IW'(NUM_REQ - 1);
         g_q             <= '0;
         tmr_q           <= '0;
         xfer_count_q    <= '0;
         timeout_count_q <= '0;
      end else begin
         state_q         <= state_d;
         desc_q          <= desc_d;
         rr_ptr_q        <= rr_ptr_d;
         g_q             <= g_d;
         tmr_q           <= tmr_d;
         xfer_count_q    <= xfer_count_d;
         timeout_count_q <= timeout_count_d;
      end
   end

   assign ucfg_dest_id         = desc_q.dest_id;
   assign ucfg_src_start_addr  = desc_q.src_addr;
   assign ucfg_dest_start_addr = desc_q.dest_addr;
   assign ucfg_byte_count      = desc_q.byte_count;
   assign ucfg_db_info         = desc_q.db_info;
   assign ucfg_wr_n            = 1'b0;
   assign xfer_count           = xfer_count_q;
   assign timeout_count        = timeout_count_q;
endmodule

// File: tb/tb_srio_initiator_arbiter.sv
// tb_srio_initiator_arbiter: directed scoreboard bench for the SRIO initiator arbiter
module tb_srio_initiator_arbiter;
   localparam int N = 4;
   localparam logic [2:0] EV_ACK = 3'd0, EV_DONE = 3'd1, EV_ERR = 3'd2, EV_TRIG = 3'd3, EV_DB = 3'd4;

   typedef struct packed {
      logic [2:0] kind;
      logic [3:0] vec;
      int         cyc;
   } ev_t;

   logic           sys_clk = 1'b0, sys_rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0, req_db = '0;
   logic [8*N-1:0] req_dest_id = '0;
   logic [32*N-1:0] req_src_addr = '0;
   logic [34*N-1:0] req_dest_addr = '0;
   logic [9*N-1:0] req_byte_count = '0;
   logic [16*N-1:0] req_db_info = '0;
   logic [N-1:0]   req_ack, req_done, req_err;
   logic [7:0]     ucfg_dest_id;
   logic [31:0]    ucfg_src_start_addr;
   logic [33:0]    ucfg_dest_start_addr;
   logic [8:0]     ucfg_byte_count;
   logic [15:0]    ucfg_db_info;
   logic           ucfg_wr_n, ucfg_normal_trigger, ucfg_db_trigger;
   logic           srio_initial_busy = 1'b0, srio_db_resp = 1'b0;
   logic [31:0]    xfer_count;
   logic [15:0]    timeout_count;

   int  cyc = 0, checks = 0, errors = 0;
   ev_t exp_q[$];

   srio_initiator_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .req_valid(req_valid), .req_dest_id(req_dest_id), .req_src_addr(req_src_addr),
      .req_dest_addr(req_dest_addr), .req_byte_count(req_byte_count), .req_db(req_db),
      .req_db_info(req_db_info), .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
      .ucfg_dest_id(ucfg_dest_id), .ucfg_src_start_addr(ucfg_src_start_addr),
      .ucfg_dest_start_addr(ucfg_dest_start_addr), .ucfg_byte_count(ucfg_byte_count),
      .ucfg_db_info(ucfg_db_info), .ucfg_wr_n(ucfg_wr_n),
      .ucfg_normal_trigger(ucfg_normal_trigger), .ucfg_db_trigger(ucfg_db_trigger),
      .srio_initial_busy(srio_initial_busy), .srio_db_resp(srio_db_resp),
      .xfer_count(xfer_count), .timeout_count(timeout_count)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic got(input logic [2:0] k, input logic [3:0] v);
      ev_t e, x;
      e = '{kind: k, vec: v, cyc: cyc};
      x = (exp_q.size() == 0) ? '{kind: 3'd7, vec: 4'd0, cyc: -1} : exp_q.pop_front();
      checks++;
      assert (e === x) else begin
         errors++;
         $error("FAIL event: got kind=%0d vec=%b cyc=%0d expected kind=%0d vec=%b cyc=%0d",
                e.kind, e.vec, e.cyc, x.kind, x.vec, x.cyc);
      end
   endtask

   always @(negedge sys_clk) begin
      if (|req_ack)            got(EV_ACK, req_ack);
      if (|req_done)           got(EV_DONE, req_done);
      if (|req_err)            got(EV_ERR, req_err);
      if (ucfg_normal_trigger) got(EV_TRIG, 4'd0);
      if (ucfg_db_trigger)     got(EV_DB, 4'd0);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] k, input int g, input int c);
      exp_q.push_back('{kind: k, vec: (k <= EV_ERR) ? 4'(1 << g) : 4'd0, cyc: c});
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [8:0] bc, input logic db, input logic [15:0] dbi);
      req_dest_id[8*i +: 8]     = 8'h40 + 8'(i);
      req_src_addr[32*i +: 32]  = 32'hA000_0000 + 32'(i) * 32'h100;
      req_dest_addr[34*i +: 34] = 34'h100 + 34'(i) * 34'h1_0000_0000;
      req_byte_count[9*i +: 9]  = bc;
      req_db[i]                 = db;
      req_db_info[16*i +: 16]   = dbi;
   endtask

   // Called in an IDLE cycle with the winning requester already valid; returns in the next IDLE cycle.
   task automatic serve(input int g, input bit db, input int rise_dly, input int len, input int resp_dly, input bit drop);
      int c, r, f, p, e;
      c = cyc; r = c + 3 + rise_dly; f = r + len; p = f + 2 + resp_dly;
      push(EV_ACK, g, c + 1);
      push(EV_TRIG, g, c + 2);
      if (db) begin
         push(EV_DB, g, f + 1);
         push(EV_DONE, g, p + 1);
         e = p + 2;
      end else begin
         push(EV_DONE, g, f + 1);
         e = f + 2;
      end
      for (int t = c; t < e; t++) begin
         srio_initial_busy = (t >= r) && (t < f);
         srio_db_resp      = db && (t == p);
         if (drop && t == c + 2) req_valid[g] = 1'b0;
         tick(1);
      end
      srio_initial_busy = 1'b0;
      srio_db_resp      = 1'b0;
   endtask

   task automatic bad(input int g);
      int c;
      c = cyc;
      req_valid[g] = 1'b1;
      push(EV_ACK, g, c + 1);
      push(EV_ERR, g, c + 1);
      tick(2);
      req_valid[g] = 1'b0;
   endtask

   task automatic tmo(input int g);
      int c;
      c = cyc;
      req_valid[g] = 1'b1;
      push(EV_ACK, g, c + 1);
      push(EV_TRIG, g, c + 2);
      push(EV_ERR, g, c + 18);
      for (int t = c; t < c + 19; t++) begin
         if (t == c + 2) req_valid[g] = 1'b0;
         tick(1);
      end
   endtask

   initial begin
      int c;
      tick(1);
      chk("rst_pulses", {req_ack, req_done, req_err, ucfg_normal_trigger, ucfg_db_trigger}, 0);
      chk("rst_ucfg", {ucfg_dest_id, ucfg_byte_count, ucfg_db_info, ucfg_wr_n}, 0);
      chk("rst_counts", {xfer_count, timeout_count}, 0);
      tick(1);
      sys_rst_n = 1'b1;
      tick(1);

      set_req(0, 9'd256, 1'b0, 16'h0);
      req_valid[0] = 1'b1;
      serve(0, 1'b0, 1, 10, 0, 1'b1);
      chk("single_bc", ucfg_byte_count, 256);
      chk("single_daddr", ucfg_dest_start_addr, 34'h100);
      chk("single_id", ucfg_dest_id, 8'h40);
      chk("single_src", ucfg_src_start_addr, 32'hA000_0000);
      chk("single_xfer", xfer_count, 1);
      chk("wr_n", ucfg_wr_n, 0);

      set_req(2, 9'd64, 1'b1, 16'h0001);
      req_valid[2] = 1'b1;
      serve(2, 1'b1, 0, 3, 2, 1'b1);
      chk("db_info", ucfg_db_info, 16'h0001);
      chk("db_xfer", xfer_count, 2);

      set_req(3, 9'd0, 1'b0, 16'h0);
      bad(3);
      chk("bc0_ucfg_bc", ucfg_byte_count, 64);
      chk("bc0_ucfg_id", ucfg_dest_id, 8'h42);
      chk("bc0_xfer", xfer_count, 2);

      set_req(0, 9'd8, 1'b0, 16'h0);
      set_req(1, 9'd16, 1'b0, 16'h0);
      set_req(2, 9'd32, 1'b0, 16'h0);
      set_req(3, 9'd1, 1'b0, 16'h0);
      req_valid = 4'hF;
      serve(0, 1'b0, 0, 1, 0, 1'b0);
      serve(1, 1'b0, 0, 1, 0, 1'b0);
      serve(2, 1'b0, 0, 1, 0, 1'b0);
      serve(3, 1'b0, 0, 1, 0, 1'b0);
      serve(0, 1'b0, -1, 2, 0, 1'b0);
      req_valid = 4'h0;
      chk("rr_xfer", xfer_count, 7);
      chk("rr_last_id", ucfg_dest_id, 8'h40);

      set_req(1, 9'd257, 1'b0, 16'h0);
      bad(1);
      chk("bc257_ucfg_bc", ucfg_byte_count, 8);
      chk("bc257_ucfg_id", ucfg_dest_id, 8'h40);

      tmo(2);
      chk("tmo_count", timeout_count, 1);
      chk("tmo_xfer", xfer_count, 7);
      set_req(1, 9'd100, 1'b0, 16'h0);
      req_valid[1] = 1'b1;
      serve(1, 1'b0, 0, 4, 0, 1'b1);
      chk("after_tmo_bc", ucfg_byte_count, 100);
      chk("after_tmo_xfer", xfer_count, 8);

      c = cyc;
      req_valid = 4'b1000;
      push(EV_ACK, 3, c + 1);
      push(EV_TRIG, 3, c + 2);
      tick(3);
      srio_initial_busy = 1'b1;
      tick(1);
      req_valid = 4'hF;
      chk("pre_rst_id", ucfg_dest_id, 8'h43);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_pulses", {req_ack, req_done, req_err, ucfg_normal_trigger, ucfg_db_trigger}, 0);
      chk("mid_rst_ucfg", {ucfg_dest_id, ucfg_byte_count, ucfg_dest_start_addr}, 0);
      chk("mid_rst_counts", {xfer_count, timeout_count}, 0);
      srio_initial_busy = 1'b0;
      tick(2);
      sys_rst_n = 1'b1;
      serve(0, 1'b0, 0, 2, 0, 1'b1);
      req_valid = 4'h0;
      chk("post_rst_xfer", xfer_count, 1);
      tick(3);
      chk("queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
